div_iter_unit: RTL and testbench

- Iterative radix-2 restoring divider; the responder side of the EX-stage ALU divide request (valid/sign/flush in, div_stall/result out).
- Accepts a held-high request from the ALU and stalls the pipeline until the quotient/remainder pair is ready.
- Returns the pair in HILO layout (HI = remainder, LO = quotient) for writeback to the hilo register.

---
 rtl/div_iter_unit_if.sv | 24 ++
 rtl/div_iter_unit.sv | 145 ++++++++++++++
 tb/tb_div_iter_unit.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/div_iter_unit_if.sv
// div_iter_unit_if: divide request/response bundle between the EX-stage ALU
// (master) and the iterative divider (slave).
interface div_iter_unit_if #(
  parameter int WIDTH = 32
);
  logic                 flush;
  logic                 valid;
  logic                 sign;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 div_stall;
  logic                 ready;
  logic [2*WIDTH-1:0]   result;

  modport master (
    output flush, valid, sign, a, b,
    input  div_stall, ready, result
  );

  modport slave (
    input  flush, valid, sign, a, b,
    output div_stall, ready, result
  );
endinterface

// File: rtl/div_iter_unit.sv
// div_iter_unit: iterative radix-2 restoring divider, one quotient bit per
// cycle. Result is {remainder, quotient} in HILO layout.
// Optional macro DIV_ITER_EARLY_OUT_EN: skip the iterations when b==0 or
// |a|<|b| and finish one cycle after the request.
module div_iter_unit #(
  parameter int WIDTH = 32,
  parameter int ITERS = WIDTH
) (
  input logic            clk,
  input logic            rst,
  div_iter_unit_if.slave bus
);

  localparam int            CW   = $clog2(ITERS + 1);
  localparam logic [CW-1:0] LAST = CW'(ITERS - 1);
  localparam logic [WIDTH:0] ONE_EXT = {{WIDTH{1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t               state, state_next;
  logic [CW-1:0]        count;
  logic [WIDTH-1:0]     rem;
  logic [WIDTH-1:0]     dq;
  logic [WIDTH:0]       divisor;
  logic                 q_neg;
  logic                 r_neg;
  logic [2*WIDTH-1:0]   result_q;

  // Operand magnitudes are formed in WIDTH+1 bits so the most negative
  // dividend/divisor still has a correct positive magnitude.
  logic             a_neg, b_neg;
  logic [WIDTH:0]   a_ext, b_ext, a_abs, b_abs;
  logic             unused_a_abs_msb;

  assign a_neg = bus.sign & bus.a[WIDTH-1];
  assign b_neg = bus.sign & bus.b[WIDTH-1];
  assign a_ext = {a_neg, bus.a};
  assign b_ext = {b_neg, bus.b};
  assign a_abs = a_neg ? (~a_ext + ONE_EXT) : a_ext;
  assign b_abs = b_neg ? (~b_ext + ONE_EXT) : b_ext;
  // A magnitude always fits in WIDTH bits, so the top bit never reaches dq.
  assign unused_a_abs_msb = a_abs[WIDTH];

  // One restoring step: shift in the next dividend bit, trial-subtract,
  // keep the difference only when it did not go negative.
  logic [WIDTH:0]   shifted, diff;
  logic [WIDTH-1:0] rem_step, dq_step;

  assign shifted  = {rem, dq[WIDTH-1]};
  assign diff     = shifted - divisor;
  assign rem_step = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
  assign dq_step  = {dq[WIDTH-2:0], ~diff[WIDTH]};

  function automatic logic [2*WIDTH-1:0] fixup(
    input logic [WIDTH-1:0] q,
    input logic [WIDTH-1:0] r,
    input logic             qn,
    input logic             rn
  );
    logic [WIDTH-1:0] qf;
    logic [WIDTH-1:0] rf;
    qf = qn ? (~q + {{(WIDTH-1){1'b0}}, 1'b1}) : q;
    rf = rn ? (~r + {{(WIDTH-1){1'b0}}, 1'b1}) : r;
    return {rf, qf};
  endfunction

`ifdef DIV_ITER_EARLY_OUT_EN
  logic               early;
  logic               b_zero;
  logic [2*WIDTH-1:0] early_result;
  assign b_zero       = (bus.b == '0);
  assign early        = b_zero | (a_abs < b_abs);
  assign early_result = fixup({WIDTH{b_zero}}, a_abs[WIDTH-1:0],
                              a_neg ^ b_neg, a_neg);
`else
  logic early;
  assign early = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Next-state logic; flush wins from any state.
  always_comb begin
    state_next = state;
    if (bus.flush) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (bus.valid) state_next = early ? DONE : BUSY;
        BUSY:    if (count == LAST) state_next = DONE;
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Datapath: latch operands on request, iterate in BUSY, register the
  // sign-corrected result on the way into DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count    <= '0;
      rem      <= '0;
      dq       <= '0;
      divisor  <= '0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      result_q <= '0;
    end else if (bus.flush) begin
      count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.valid) begin
            rem     <= '0;
            dq      <= a_abs[WIDTH-1:0];
            divisor <= b_abs;
            q_neg   <= a_neg ^ b_neg;
            r_neg   <= a_neg;
            count   <= '0;
`ifdef DIV_ITER_EARLY_OUT_EN
            if (early) result_q <= early_result;
`endif
          end
        end
        BUSY: begin
          rem   <= rem_step;
          dq    <= dq_step;
          count <= count + CW'(1);
          if (count == LAST) result_q <= fixup(dq_step, rem_step, q_neg, r_neg);
        end
        default: ;
      endcase
    end
  end

  assign bus.div_stall = rst & ~bus.flush &
                         (((state == IDLE) & bus.valid) | (state == BUSY));
  assign bus.ready     = (state == DONE) & ~bus.flush;
  assign bus.result    = result_q;

endmodule

// File: tb/tb_div_iter_unit.sv
// tb_div_iter_unit: directed and randomized checks of div_iter_unit against
// an arithmetic reference model (latency, stall length, result, flush, reset).
module tb_div_iter_unit;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  logic [63:0] last_exp = '0;

  div_iter_unit_if #(.WIDTH(32)) bus ();

  div_iter_unit #(.WIDTH(32), .ITERS(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic longint magnitude(input logic [31:0] x, input logic sgn);
    longint m;
    m = longint'(x);
    if (sgn && x[31]) m = 64'h1_0000_0000 - m;
    return m;
  endfunction

  // Reference: divide magnitudes, divide-by-zero gives all-ones quotient
  // and the dividend as remainder, then apply the signs.
  function automatic logic [63:0] ref_div(input logic [31:0] x, input logic [31:0] y, input logic sgn);
    longint      ma, mb, qm, rm;
    logic [31:0] q, r;
    logic        xn, yn;
    xn = sgn && x[31];
    yn = sgn && y[31];
    ma = magnitude(x, sgn);
    mb = magnitude(y, sgn);
    if (mb == 0) begin
      qm = 64'h0000_0000_FFFF_FFFF;
      rm = ma;
    end else begin
      qm = ma / mb;
      rm = ma % mb;
    end
    q = qm[31:0];
    r = rm[31:0];
    if (xn ^ yn) q = 32'd0 - q;
    if (xn)      r = 32'd0 - r;
    return {r, q};
  endfunction

  function automatic int exp_lat(input logic [31:0] x, input logic [31:0] y, input logic sgn);
`ifdef DIV_ITER_EARLY_OUT_EN
    if (y == 32'd0 || magnitude(x, sgn) < magnitude(y, sgn)) return 1;
`endif
    return 33;
  endfunction

  // Called #1 after a rising edge; returns #1 after a rising edge.
  task automatic applyStimulus(input logic [31:0] x, input logic [31:0] y, input logic sgn,
                               input logic [63:0] exp, input int lat, input bit keep_valid);
    int          ready_cyc;
    int          stalls;
    logic [63:0] got;
    ready_cyc = -1;
    stalls    = 0;
    got       = '0;
    bus.a     = x;
    bus.b     = y;
    bus.sign  = sgn;
    bus.valid = 1'b1;
    for (int c = 0; c < 120 && ready_cyc < 0; c++) begin
      @(negedge clk);
      if (bus.div_stall) stalls++;
      if (bus.ready) begin
        ready_cyc = c;
        got       = bus.result;
      end
    end
    checkOutput("ready_cycle", 64'(ready_cyc), 64'(lat));
    checkOutput("stall_cycles", 64'(stalls), 64'(lat));
    checkOutput("result", got, exp);
    last_exp = exp;
    @(posedge clk);
    #1;
    if (!keep_valid) begin
      bus.valid = 1'b0;
      @(negedge clk);
      checkOutput("ready_pulse_end", 64'(bus.ready), 64'd0);
      checkOutput("result_hold", bus.result, exp);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic        rs;
    int          pulses;

    rst       = 1'b0;
    bus.flush = 1'b0;
    bus.valid = 1'b1;
    bus.sign  = 1'b0;
    bus.a     = 32'd100;
    bus.b     = 32'd7;
    #12;
    checkOutput("reset_stall", 64'(bus.div_stall), 64'd0);
    checkOutput("reset_ready", 64'(bus.ready), 64'd0);
    checkOutput("reset_result", bus.result, 64'd0);
    bus.valid = 1'b0;
    #10 rst = 1'b1;
    @(posedge clk);
    #1;

    // Directed vectors.
    applyStimulus(32'd100, 32'd7, 1'b0, 64'h00000002_0000000E, 33, 1'b0);
    applyStimulus(32'hFFFFFFF9, 32'd2, 1'b1, 64'hFFFFFFFF_FFFFFFFD, 33, 1'b0);
    applyStimulus(32'd7, 32'hFFFFFFFE, 1'b1, 64'h00000001_FFFFFFFD, 33, 1'b0);
    applyStimulus(32'h80000000, 32'hFFFFFFFF, 1'b1, 64'h00000000_80000000, 33, 1'b0);
    applyStimulus(32'd5, 32'd0, 1'b0, 64'h00000005_FFFFFFFF, exp_lat(32'd5, 32'd0, 1'b0), 1'b0);

    // Flush in BUSY cycle 10.
    bus.a = 32'd1000; bus.b = 32'd10; bus.sign = 1'b0; bus.valid = 1'b1;
    repeat (10) @(posedge clk);
    #1 bus.flush = 1'b1;
    @(negedge clk);
    checkOutput("flush_stall", 64'(bus.div_stall), 64'd0);
    checkOutput("flush_ready", 64'(bus.ready), 64'd0);
    @(posedge clk);
    #1 bus.flush = 1'b0; bus.valid = 1'b0;
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.ready) pulses++;
    end
    checkOutput("flush_no_ready", 64'(pulses), 64'd0);
    checkOutput("flush_result_kept", bus.result, last_exp);
    @(posedge clk);
    #1;
    applyStimulus(32'd9, 32'd3, 1'b0, 64'h00000000_00000003, 33, 1'b0);

    // Back-to-back with valid held high across both divides.
    applyStimulus(32'd20, 32'd3, 1'b0, 64'h00000002_00000006, 33, 1'b1);
    applyStimulus(32'hFFFFFFFF, 32'd16, 1'b0, 64'h0000000F_0FFFFFFF, 33, 1'b0);

    // Asynchronous reset in BUSY cycle 5.
    bus.a = 32'd12345; bus.b = 32'd17; bus.sign = 1'b0; bus.valid = 1'b1;
    repeat (5) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    checkOutput("async_reset_stall", 64'(bus.div_stall), 64'd0);
    checkOutput("async_reset_ready", 64'(bus.ready), 64'd0);
    checkOutput("async_reset_result", bus.result, 64'd0);
    @(negedge clk);
    checkOutput("reset_hold_stall", 64'(bus.div_stall), 64'd0);
    bus.valid = 1'b0;
    #3 rst = 1'b1;
    last_exp = '0;
    @(posedge clk);
    #1;
    applyStimulus(32'd50, 32'd5, 1'b0, 64'h00000000_0000000A, 33, 1'b0);

    // Small-dividend case (early-out path when enabled).
    applyStimulus(32'd3, 32'd8, 1'b0, 64'h00000003_00000000, exp_lat(32'd3, 32'd8, 1'b0), 1'b0);

    // Randomized operands against the reference model.
    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom_range(0, 1));
      case (i % 6)
        1: rb = 32'($urandom_range(1, 15));
        2: rb = 32'd0;
        3: ra = 32'($urandom_range(0, 20));
        4: rb = 32'hFFFFFFFF - 32'($urandom_range(0, 3));
        default: ;
      endcase
      applyStimulus(ra, rb, rs, ref_div(ra, rb, rs), exp_lat(ra, rb, rs), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
